cnt_shift_framer: RTL and testbench

Parametrised shift-register/bit-counter unit that serialises (TX) or deserialises (RX) one WIDTH-bit frame per start request.
- The built-in bit counter terminates the frame, so no external carry-out gating is needed.
- Adds direction mode, MSB/LSB-first ordering, shift stall, abort and a framed done/valid handshake.
- Sits between serial links and parallel datapath registers in the course lab designs.

---
 rtl/cnt_shift_framer_if.sv | 30 +++
 rtl/cnt_shift_framer.sv | 99 +++++++++
 tb/tb_cnt_shift_framer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_shift_framer_if.sv
// Handshake/data bundle between a framer and its controlling datapath.
// master drives the request side; slave is the framer itself.
interface cnt_shift_framer_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             mode;
  logic             start;
  logic             en;
  logic             abort;
  logic             si;
  logic [WIDTH-1:0] pi;
  logic             so;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output mode, start, en, abort, si, pi,
    input  so, po, po_valid, done, busy, bit_cnt
  );

  modport slave (
    input  mode, start, en, abort, si, pi,
    output so, po, po_valid, done, busy, bit_cnt
  );
endinterface

// File: rtl/cnt_shift_framer.sv
// Single-frame shift register with built-in bit counter: serialises pi (TX) or
// assembles si into po (RX), with stall, abort and a one-cycle done handshake.
module cnt_shift_framer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  cnt_shift_framer_if.slave bus
);
  localparam int unsigned      CNT_W   = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_shreg, w_shreg_d;
  logic [WIDTH-1:0] r_po, w_po_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_mode, w_mode_d;
  logic [WIDTH-1:0] w_shifted;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_so_bit;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_so_bit  = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];

  // TX drains toward the output end zero-filled; RX pulls si in at the far end
  always_comb begin
    w_shifted = r_shreg;
    if (r_mode) begin
      if (LSB_FIRST) w_shifted = r_shreg >> 1;
      else           w_shifted = r_shreg << 1;
    end else begin
      if (LSB_FIRST) w_shifted = {bus.si, r_shreg[WIDTH-1:1]};
      else           w_shifted = {r_shreg[WIDTH-2:0], bus.si};
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_shreg_d = r_shreg;
    w_po_d    = r_po;
    w_cnt_d   = r_cnt;
    w_mode_d  = r_mode;
    case (r_state)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          w_state_d = StShift;
          w_mode_d  = bus.mode;
          w_cnt_d   = '0;
          if (bus.mode) w_shreg_d = bus.pi;
        end
      end
      StShift: begin
        if (bus.abort) begin
          w_state_d = StIdle;
          w_shreg_d = '0;
        end else if (bus.en) begin
          w_cnt_d   = w_cnt_inc;
          w_shreg_d = w_shifted;
          if (w_cnt_inc == LastCnt) begin
            w_state_d = StDone;
            if (!r_mode) w_po_d = w_shifted;
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
        if (bus.abort) w_shreg_d = '0;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_shreg <= '0;
      r_po    <= '0;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_shreg <= w_shreg_d;
      r_po    <= w_po_d;
      r_cnt   <= w_cnt_d;
      r_mode  <= w_mode_d;
    end
  end

  // An abort landing in the DONE cycle cancels the completion handshake
  assign bus.done     = (r_state == StDone) && !bus.abort;
  assign bus.po_valid = bus.done && !r_mode;
  assign bus.busy     = (r_state != StIdle);
  assign bus.so       = (r_state == StShift) && r_mode && w_so_bit;
  assign bus.po       = r_po;
  assign bus.bit_cnt  = r_cnt;
endmodule

// File: tb/tb_cnt_shift_framer.sv
// Drives MSB-first and LSB-first framers in lockstep against a bit-list model,
// plus a vector table and hand-written reset/abort/collision sequences.
module tb_cnt_shift_framer;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cnt_shift_framer_if #(.WIDTH(W)) bus_m ();
  cnt_shift_framer_if #(.WIDTH(W)) bus_l ();

  cnt_shift_framer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst_n(rst_n), .bus(bus_m));
  cnt_shift_framer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(bus_l));

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 shifting, 2 done; index 0 MSB-first, 1 LSB-first
  int         m_ph   [2];
  int         m_cnt  [2];
  bit         m_mode [2];
  logic [W-1:0] m_pi [2];
  logic [W-1:0] m_po [2];
  bit         m_bits [2][W];

  logic cur_start, cur_mode, cur_en, cur_abort, cur_si;
  logic [W-1:0] cur_pi;

  logic o_so [2], o_done [2], o_pv [2], o_busy [2];
  logic [W-1:0] o_po [2];
  logic [3:0]   o_cnt [2];

  typedef struct {
    bit           mode;
    logic [W-1:0] data;
    logic [W-1:0] exp_m;
    logic [W-1:0] exp_l;
    int           stall_after;
    int           stall_len;
    bit           noise;
  } vec_t;

  vec_t vecs [7];
  logic [W-1:0] exp_po_m = '0;
  logic [W-1:0] exp_po_l = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_cnt[k] = 0; m_mode[k] = 1'b0; m_pi[k] = '0; m_po[k] = '0;
    end
  endfunction

  function automatic logic [W-1:0] assemble(input int k);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (k == 1) w[i] = m_bits[k][i];
      else        w[W-1-i] = m_bits[k][i];
    end
    return w;
  endfunction

  task automatic sample();
    o_so[0] = bus_m.so;   o_so[1] = bus_l.so;
    o_done[0] = bus_m.done; o_done[1] = bus_l.done;
    o_pv[0] = bus_m.po_valid; o_pv[1] = bus_l.po_valid;
    o_busy[0] = bus_m.busy; o_busy[1] = bus_l.busy;
    o_po[0] = bus_m.po;   o_po[1] = bus_l.po;
    o_cnt[0] = bus_m.bit_cnt; o_cnt[1] = bus_l.bit_cnt;
  endtask

  task automatic check_model();
    logic e_so, e_done;
    for (int k = 0; k < 2; k++) begin
      e_so = 1'b0;
      if (m_ph[k] == 1 && m_mode[k])
        e_so = (k == 1) ? m_pi[k][m_cnt[k]] : m_pi[k][W-1-m_cnt[k]];
      e_done = (m_ph[k] == 2) && !cur_abort;
      chk($sformatf("so[%0d]", k), 32'(o_so[k]), 32'(e_so));
      chk($sformatf("done[%0d]", k), 32'(o_done[k]), 32'(e_done));
      chk($sformatf("po_valid[%0d]", k), 32'(o_pv[k]), 32'(e_done && !m_mode[k]));
      chk($sformatf("busy[%0d]", k), 32'(o_busy[k]), 32'(m_ph[k] != 0));
      chk($sformatf("po[%0d]", k), 32'(o_po[k]), 32'(m_po[k]));
      chk($sformatf("bit_cnt[%0d]", k), 32'(o_cnt[k]), 32'(m_cnt[k]));
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      case (m_ph[k])
        0: if (cur_start && !cur_abort) begin
          m_ph[k] = 1; m_mode[k] = cur_mode; m_cnt[k] = 0;
          if (cur_mode) m_pi[k] = cur_pi;
        end
        1: if (cur_abort) m_ph[k] = 0;
           else if (cur_en) begin
             m_bits[k][m_cnt[k]] = cur_si;
             m_cnt[k]++;
             if (m_cnt[k] == W) begin
               m_ph[k] = 2;
               if (!m_mode[k]) m_po[k] = assemble(k);
             end
           end
        default: m_ph[k] = 0;
      endcase
    end
  endtask

  task automatic drive(input logic st, md, e, ab, s, input logic [W-1:0] p);
    cur_start = st; cur_mode = md; cur_en = e; cur_abort = ab; cur_si = s; cur_pi = p;
    bus_m.start = st; bus_m.mode = md; bus_m.en = e; bus_m.abort = ab;
    bus_m.si = s; bus_m.pi = p;
    bus_l.start = st; bus_l.mode = md; bus_l.en = e; bus_l.abort = ab;
    bus_l.si = s; bus_l.pi = p;
  endtask

  // One clock: apply inputs, check outputs at the falling edge, advance the model
  task automatic cycle(input logic st, md, e, ab, s, input logic [W-1:0] p);
    drive(st, md, e, ab, s, p);
    @(negedge clk);
    sample();
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_frame(input vec_t v, output logic [W-1:0] so_m, output logic [W-1:0] so_l,
                           output int busy_n, output int done_n, output int pv_n);
    busy_n = 0; done_n = 0; pv_n = 0; so_m = '0; so_l = '0;
    cycle(1'b1, v.mode, 1'b0, 1'b0, 1'b0, v.mode ? v.data : W'($urandom));
    for (int b = 0; b < W; b++) begin
      if (b == v.stall_after) begin
        for (int s = 0; s < v.stall_len; s++) begin
          cycle(v.noise, ~v.mode, 1'b0, 1'b0, 1'($urandom), W'($urandom));
          chk("stall_cnt", 32'(o_cnt[0]), 32'(v.stall_after));
          busy_n += int'(o_busy[0]); done_n += int'(o_done[0]); pv_n += int'(o_pv[0]);
        end
      end
      cycle(v.noise, 1'($urandom), 1'b1, 1'b0, v.data[W-1-b], W'($urandom));
      so_m[W-1-b] = o_so[0];
      so_l[W-1-b] = o_so[1];
      busy_n += int'(o_busy[0]); done_n += int'(o_done[0]); pv_n += int'(o_pv[0]);
    end
    cycle(v.noise, 1'($urandom), 1'b1, 1'b0, 1'($urandom), W'($urandom));
    busy_n += int'(o_busy[0]); done_n += int'(o_done[0]); pv_n += int'(o_pv[0]);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    busy_n += int'(o_busy[0]); done_n += int'(o_done[0]); pv_n += int'(o_pv[0]);
  endtask

  task automatic check_frame(input vec_t v);
    logic [W-1:0] so_m, so_l;
    int busy_n, done_n, pv_n;
    run_frame(v, so_m, so_l, busy_n, done_n, pv_n);
    if (v.mode) begin
      chk("tx_so_msb", 32'(so_m), 32'(v.exp_m));
      chk("tx_so_lsb", 32'(so_l), 32'(v.exp_l));
      chk("tx_pv_cnt", 32'(pv_n), 32'd0);
    end else begin
      exp_po_m = v.exp_m;
      exp_po_l = v.exp_l;
      chk("rx_pv_cnt", 32'(pv_n), 32'd1);
    end
    chk("frame_po_msb", 32'(o_po[0]), 32'(exp_po_m));
    chk("frame_po_lsb", 32'(o_po[1]), 32'(exp_po_l));
    chk("frame_done_cnt", 32'(done_n), 32'd1);
    chk("frame_busy_cnt", 32'(busy_n), 32'(W + 1 + v.stall_len));
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 8'hA5, 8'hA5, -1, 0, 1'b0};
    vecs[1] = '{1'b0, 8'hCA, 8'hCA, 8'h53, -1, 0, 1'b0};
    vecs[2] = '{1'b1, 8'h1E, 8'h1E, 8'h78, -1, 0, 1'b0};
    vecs[3] = '{1'b0, 8'h96, 8'h96, 8'h69, -1, 0, 1'b0};
    vecs[4] = '{1'b0, 8'hCA, 8'hCA, 8'h53,  4, 3, 1'b0};
    vecs[5] = '{1'b1, 8'hA5, 8'hA5, 8'hA5,  5, 2, 1'b1};
    vecs[6] = '{1'b0, 8'h96, 8'h96, 8'h69,  2, 1, 1'b1};

    model_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    sample();
    check_model();
    chk("reset_busy", 32'(o_busy[0]), 32'd0);
    chk("reset_po", 32'(o_po[1]), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) check_frame(vecs[i]);

    // Asynchronous reset after four TX bits, away from any clock edge
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
    for (int b = 0; b < 4; b++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1 sample();
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk("async_busy", 32'(o_busy[k]), 32'd0);
      chk("async_so", 32'(o_so[k]), 32'd0);
      chk("async_done", 32'(o_done[k]), 32'd0);
      chk("async_cnt", 32'(o_cnt[k]), 32'd0);
      chk("async_po", 32'(o_po[k]), 32'd0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_po_m = '0;
    exp_po_l = '0;
    check_frame(vecs[1]);

    // Abort after five RX bits: no handshake, po kept, partial count kept
    begin
      int pv_n;
      pv_n = 0;
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      for (int b = 0; b < 5; b++) begin
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom), '0);
        pv_n += int'(o_pv[0]) + int'(o_pv[1]);
      end
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, '0);
      pv_n += int'(o_pv[0]) + int'(o_pv[1]);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      pv_n += int'(o_pv[0]) + int'(o_pv[1]);
      chk("abort_busy", 32'(o_busy[0]), 32'd0);
      chk("abort_cnt", 32'(o_cnt[0]), 32'd5);
      chk("abort_po_msb", 32'(o_po[0]), 32'(exp_po_m));
      chk("abort_po_lsb", 32'(o_po[1]), 32'(exp_po_l));
      chk("abort_pv_cnt", 32'(pv_n), 32'd0);
      // start and abort together in idle: start is dropped
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("start_abort_busy", 32'(o_busy[0]), 32'd0);
      chk("start_abort_cnt", 32'(o_cnt[1]), 32'd5);
    end

    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0), 1'($urandom), W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
